// File: rtl/piezo_alert_mon.sv
// piezo_alert_mon: qualifies over-speed and battery-low alerts with run-length
// filters and gates the steer tune request behind them.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   vld               single-cycle sample strobe for batt/lft_spd/rght_spd
//   batt              unsigned battery reading
//   lft_spd, rght_spd signed wheel speeds
//   en_steer_in       rider-on / steer-enable level
//   too_fast          filtered over-speed alert (registered)
//   batt_low          filtered battery-low alert (registered)
//   en_steer          steer request, suppressed by either alert (registered)
//
// Build option: define PIEZO_ALERT_HYST_EN to compile in clear-side hysteresis
// (SPD_LO, BATT_HYST). Without it each alert clears on the inverse of its set
// condition and those two parameters are unused.

// Run-length filter: alert flips only after FILT_CNT consecutive qualifying samples.
module piezo_alert_filt #(
  parameter int unsigned FILT_CNT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  logic set,
  input  logic clr,
  output logic alert
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W:0] FILT_LIM = (CNT_W+1)'(FILT_CNT);

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_PEND_SET = 2'd1,
    ST_ALERT    = 2'd2,
    ST_PEND_CLR = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alert_q, alert_d;
  logic [CNT_W:0]   cnt_inc_c;
  logic             run_done_c;

  // cnt is 0 in OK/ALERT, so run_done also covers the FILT_CNT == 1 shortcut.
  assign cnt_inc_c  = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign run_done_c = (cnt_inc_c == FILT_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OK;
      cnt_q   <= '0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alert_q <= alert_d;
    end
  end

  // Next-state and count update; everything holds while vld is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (vld) begin
      unique case (state_q)
        ST_OK: begin
          if (set) begin
            state_d = run_done_c ? ST_ALERT : ST_PEND_SET;
            cnt_d   = run_done_c ? '0 : cnt_inc_c[CNT_W-1:0];
          end
        end
        ST_PEND_SET: begin
          if (!set) begin
            state_d = ST_OK;
            cnt_d   = '0;
          end else if (run_done_c) begin
            state_d = ST_ALERT;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc_c[CNT_W-1:0];
          end
        end
        ST_ALERT: begin
          if (clr) begin
            state_d = run_done_c ? ST_OK : ST_PEND_CLR;
            cnt_d   = run_done_c ? '0 : cnt_inc_c[CNT_W-1:0];
          end
        end
        ST_PEND_CLR: begin
          if (!clr) begin
            state_d = ST_ALERT;
            cnt_d   = '0;
          end else if (run_done_c) begin
            state_d = ST_OK;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_inc_c[CNT_W-1:0];
          end
        end
        default: begin
          state_d = ST_OK;
          cnt_d   = '0;
        end
      endcase
    end
    alert_d = (state_d == ST_ALERT) || (state_d == ST_PEND_CLR);
  end

  assign alert = alert_q;

endmodule

module piezo_alert_mon #(
  parameter int unsigned FILT_CNT  = 16,
  parameter logic [11:0] SPD_HI    = 12'd1536,
  parameter logic [11:0] SPD_LO    = 12'd1280,
  parameter logic [11:0] BATT_LO   = 12'd2048,
  parameter logic [11:0] BATT_HYST = 12'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [11:0] batt,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        en_steer_in,
  output logic        too_fast,
  output logic        batt_low,
  output logic        en_steer
);

  logic [12:0] spd_sum_c;
  logic [11:0] spd_avg_c;
  logic [11:0] spd_mag_c;
  logic        spd_set_c, spd_clr_c;
  logic        batt_set_c, batt_clr_c;
  logic        too_fast_w, batt_low_w;
  logic        en_steer_q, en_steer_d;

  // Average of the two wheels, then magnitude; -2048 maps to 12'h800 (2048).
  assign spd_sum_c = {lft_spd[11], lft_spd} + {rght_spd[11], rght_spd};
  assign spd_avg_c = spd_sum_c[12:1];
  assign spd_mag_c = spd_avg_c[11] ? 12'(~spd_avg_c + 12'd1) : spd_avg_c;

  assign spd_set_c  = (spd_mag_c > SPD_HI);
  assign batt_set_c = (batt < BATT_LO);

`ifdef PIEZO_ALERT_HYST_EN
  // Clear threshold widened to 13 bits so BATT_LO + BATT_HYST cannot wrap.
  assign spd_clr_c  = (spd_mag_c < SPD_LO);
  assign batt_clr_c = ({1'b0, batt} >= (13'(BATT_LO) + 13'(BATT_HYST)));
`else
  logic unused_hyst_c;
  assign unused_hyst_c = ^{SPD_LO, BATT_HYST};
  assign spd_clr_c     = !spd_set_c;
  assign batt_clr_c    = !batt_set_c;
`endif

  piezo_alert_filt #(.FILT_CNT(FILT_CNT)) u_spd_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (vld),
    .set   (spd_set_c),
    .clr   (spd_clr_c),
    .alert (too_fast_w)
  );

  piezo_alert_filt #(.FILT_CNT(FILT_CNT)) u_batt_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (vld),
    .set   (batt_set_c),
    .clr   (batt_clr_c),
    .alert (batt_low_w)
  );

  // Steer request follows the input one cycle late, blocked by either live alert.
  assign en_steer_d = en_steer_in & ~too_fast_w & ~batt_low_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_steer_q <= 1'b0;
    end else begin
      en_steer_q <= en_steer_d;
    end
  end

  assign too_fast = too_fast_w;
  assign batt_low = batt_low_w;
  assign en_steer = en_steer_q;

endmodule

// File: doc/piezo_alert_mon.md
# piezo_alert_mon

Alert qualifier that sits directly upstream of the piezo driver in the Segway control path. It watches A2D battery samples, left/right wheel speed and the rider-detect steer enable. It produces the filtered level signals `too_fast`, `batt_low` and `en_steer` that the piezo driver's command register latches. Each alert is set and cleared only after a run of consecutive qualifying samples, so that noise near a threshold cannot chatter the tune selection.

## Interface
- `FILT_CNT`, default 16: consecutive qualifying `vld` samples required to set or clear an alert; legal range 1–255.
- `SPD_HI`, default 12'd1536: over-speed set threshold on averaged speed magnitude.
- `SPD_LO`, default 12'd1280: over-speed clear threshold; used only with hysteresis compiled in; must be ≤ `SPD_HI`.
- `BATT_LO`, default 12'd2048: battery-low set threshold.
- `BATT_HYST`, default 12'd64: battery clear margin above `BATT_LO`; used only with hysteresis compiled in.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `vld` in 1: single-cycle strobe marking a new sample on `batt`, `lft_spd` and `rght_spd`.
- `batt` in 12: unsigned battery reading.
- `lft_spd` in 12: signed (two's complement) left wheel speed.
- `rght_spd` in 12: signed (two's complement) right wheel speed.
- `en_steer_in` in 1: rider-on / steer-enable level from the balance controller.
- `too_fast` out 1: registered over-speed alert level.
- `batt_low` out 1: registered battery-low alert level.
- `en_steer` out 1: registered steer tune request.

## Operation
- Speed datapath:
  - sum = sext13(`lft_spd`) + sext13(`rght_spd`).
  - avg = sum >>> 1, 12-bit signed.
  - mag = |avg|, 12-bit unsigned. avg = −2048 gives mag = 2048; no overflow.
- Qualifiers, evaluated only in cycles where `vld` = 1:
  - spd_set = mag > `SPD_HI`.
  - batt_set = `batt` < `BATT_LO`.
  - Clear conditions depend on configuration; see Configuration.
- Two independent, identical filter FSMs: one for speed, one for battery. Each has an 8-bit counter `cnt`.
  - States:
    - OK: alert = 0. On `vld` & set: `cnt`←1 and go to PEND_SET; if `FILT_CNT` = 1, go straight to ALERT instead.
    - PEND_SET: alert = 0. On `vld` & set: `cnt`+1; when `cnt`+1 = `FILT_CNT`, go to ALERT and set `cnt`←0. On `vld` & !set: go to OK and set `cnt`←0.
    - ALERT: alert = 1. On `vld` & clr: `cnt`←1 and go to PEND_CLR; if `FILT_CNT` = 1, go straight to OK.
    - PEND_CLR: alert = 1. On `vld` & clr: `cnt`+1; when `cnt`+1 = `FILT_CNT`, go to OK and set `cnt`←0. On `vld` & !clr: go to ALERT and set `cnt`←0.
  - With `vld` = 0, state and `cnt` hold.
  - `cnt` never exceeds `FILT_CNT`; there is no wrap.
- Outputs:
  - `too_fast` = speed FSM alert.
  - `batt_low` = battery FSM alert.
  - `en_steer` = registered `en_steer_in` & !`too_fast` & !`batt_low`. Higher-priority tunes suppress the steer request.
- Simultaneous alerts: `too_fast` and `batt_low` may both be 1. Priority between them belongs to the downstream driver; this block does not arbitrate.

## Timing
- Reset values: all FSMs in OK, all `cnt` = 0, `too_fast` = 0, `batt_low` = 0, `en_steer` = 0.
- Reset asserted mid-run (for example in PEND_SET with `cnt` = 10): immediate return to reset values; no partial count survives.
- Alert latency: the output changes on the same clock edge that samples the `FILT_CNT`-th consecutive qualifying `vld`. The speed datapath is combinational into the FSM, so there is no extra pipeline stage.
- `en_steer` latency: exactly 1 cycle after `en_steer_in` changes. It deasserts on the edge after `too_fast` or `batt_low` rises.
- `vld` held high continuously is legal; every cycle is then a sample.
- Samples are not required to be periodic.
- Inputs are assumed synchronous to `clk`.

## Configuration
- Macro: `PIEZO_ALERT_HYST_EN`.
- Defined, hysteresis is compiled in:
  - spd_clr = mag < `SPD_LO`.
  - batt_clr = `batt` ≥ `BATT_LO` + `BATT_HYST`, computed 13-bit so there is no wrap.
- Undefined:
  - spd_clr = !spd_set.
  - batt_clr = !batt_set.
  - The `SPD_LO` and `BATT_HYST` parameters are ignored and their logic is removed.

## Test plan
- Reset and speed set:
  - Stimulus: reset, then 16 `vld` pulses with `lft_spd` = `rght_spd` = 1600.
  - Required response: `too_fast` 0 through the 15th pulse and 1 on the edge of the 16th; `batt_low` = 0 and `en_steer` = 0 throughout.
- Interrupted speed run:
  - Stimulus: 10 pulses at speed 1600, one pulse at speed 0, then 15 pulses at 1600.
  - Required response: `too_fast` stays 0; the count restarts after the interruption.
- Negative speed and extremes:
  - Stimulus: `lft_spd` = `rght_spd` = −1600 for 16 pulses → `too_fast` = 1.
  - Stimulus: both inputs at −2048 → mag = 2048, with no overflow.
- Battery hysteresis, with `PIEZO_ALERT_HYST_EN` defined:
  - Stimulus: `batt` = 2000 for 16 pulses → `batt_low` = 1.
  - Stimulus: `batt` = 2080 for 16 pulses → `batt_low` stays 1, since 2080 < 2112.
  - Stimulus: `batt` = 2112 for 16 pulses → `batt_low` = 0 on the 16th pulse.
  - Without the macro, the `batt` = 2080 run clears `batt_low` on its 16th pulse.
- Steer gating:
  - Stimulus: `en_steer_in` = 1 with no alerts → `en_steer` = 1 one cycle later.
  - Stimulus: then drive an over-speed run → `en_steer` = 0 one cycle after `too_fast` rises, and `en_steer` = 1 again one cycle after `too_fast` clears.
- Reset mid-filter:
  - Stimulus: assert `rst_n` = 0 while the battery FSM is in PEND_CLR with `cnt` = 8.
  - Required response: `batt_low` = 0 immediately (asynchronous reset). After release, 16 fresh low samples are required to set it again.
